// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - sweeps a 4-input function block through all minterms and captures its truth table (optional macro: SCAN_GRAY_EN)
module minterm_scanner #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Settle counter runs 0..SETTLE-1; the last value hands over to SAMPLE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] idx;
    logic [3:0] settle_cnt;
    logic [3:0] code_q;

    // Minterm presented for a given sweep index: Gray order keeps one input toggling per step.
    function automatic logic [3:0] drive_code(input logic [3:0] i);
`ifdef SCAN_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign a = code_q[3];
    assign b = code_q[2];
    assign c = code_q[1];
    assign d = code_q[0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: IDLE -> DRIVE (SETTLE cycles) -> SAMPLE, repeated 16 times, then DONE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nx = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (idx == 4'd15) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_DRIVE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath: minterm drive, settle timing, table capture and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            settle_cnt <= 4'd0;
            code_q     <= 4'd0;
            table_out  <= 16'd0;
            ones_cnt   <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= (state_nx == S_DRIVE) || (state_nx == S_SAMPLE);
            done <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx        <= 4'd0;
                        settle_cnt <= 4'd0;
                        table_out  <= 16'd0;
                        ones_cnt   <= 5'd0;
                        code_q     <= drive_code(4'd0);
                    end
                end
                S_DRIVE: begin
                    if (settle_cnt != SETTLE_LAST) begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    table_out[drive_code(idx)] <= f;
                    ones_cnt                   <= ones_cnt + {4'd0, f};
                    if (idx != 4'd15) begin
                        idx        <= idx + 4'd1;
                        settle_cnt <= 4'd0;
                        code_q     <= drive_code(idx + 4'd1);
                    end else begin
                        code_q     <= 4'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
